axis_rr_pkt_arbiter: RTL and testbench
======================================

// Module: axis_rr_pkt_arbiter
// PURPOSE
// Packet-granular round-robin arbiter sharing one routed AXI4-Stream (tdata/tkeep/tid/tlast) among N_SRC sources.
// Sits in front of the RoCE TX path, where several queue engines contend for a single outbound stream.
// Once a source is granted, it owns the output until its tlast beat is accepted; beats of different packets never interleave.
// The output carries the source index, and a per-source accepted-packet counter is exported for status registers.
// PARAMETERS
// N_SRC      4    number of source streams, 2..16
// DATA_BITS  512  tdata width; KEEP_BITS = DATA_BITS/8
// ID_BITS    6    tid width (process id), passed through unchanged
// SRC_BITS   $clog2(N_SRC)  width of the source index (derived localparam)
// PORTS
// aclk        in   1                  clock
// areset      in   1                  synchronous, active-high reset
// s_tvalid    in   N_SRC              per-source valid
// s_tready    out  N_SRC              per-source ready
// s_tdata     in   N_SRC*DATA_BITS    source i occupies slice [i*DATA_BITS +: DATA_BITS]
// s_tkeep     in   N_SRC*KEEP_BITS    per-source byte enables
// s_tid       in   N_SRC*ID_BITS      per-source tid
// s_tlast     in   N_SRC              per-source end of packet
// m_tvalid    out  1                  output valid
// m_tready    in   1                  output ready
// m_tdata     out  DATA_BITS          granted source data
// m_tkeep     out  KEEP_BITS          granted source keep
// m_tid       out  ID_BITS            granted source tid
// m_tlast     out  1                  granted source last
// m_src       out  SRC_BITS           index of granted source, stable for the whole packet
// pkt_cnt     out  N_SRC*32           per-source count of accepted tlast beats
// BEHAVIOUR
// - One clock, aclk. Reset is synchronous and active-high on areset.
// - On reset:
//   - state = IDLE; m_tvalid = 0; s_tready = 0.
//   - m_src = 0; last-grant pointer = N_SRC-1, so source 0 wins first.
//   - All pkt_cnt = 0.
// - FSM IDLE:
//   - If any s_tvalid is high, grant the first requesting index searching from (ptr+1) mod N_SRC upward, with wrap-around.
//   - Register the grant into g and m_src, then go to BUSY.
//   - All s_tready = 0 and m_tvalid = 0 while in IDLE.
//   - A packet's first beat can be accepted at the earliest 1 cycle after its tvalid is seen in IDLE.
// - FSM BUSY (combinational path from the granted source, zero added latency):
//   - m_tvalid = s_tvalid[g]; m_tdata, m_tkeep, m_tid, m_tlast are taken from slice g.
//   - s_tready[g] = m_tready; every other s_tready = 0.
//   - Beat transfer = m_tvalid & m_tready.
//   - Transfer with m_tlast = 1: ptr <= g, pkt_cnt[g] += 1 (wraps modulo 2^32), state <= IDLE.
//   - A source deasserting tvalid mid-packet holds the grant; there is no timeout.
// - Fairness: one IDLE bubble cycle between packets. Back-to-back single-beat packets therefore peak at 50% throughput.
//   - Any continuously requesting source is served within N_SRC-1 packets of others.
// - Simultaneous requests in IDLE: the round-robin search order alone decides the winner; no fixed priority.
// - A request arriving at a source while another source is in BUSY waits. It does not affect the current packet.
// - areset asserted mid-packet: abort the packet and return to the reset state next cycle.
//   - The partial packet is not counted.
//   - Downstream truncation is the system's responsibility.
// - m_src and pkt_cnt are registered outputs. m_tdata, m_tkeep, m_tid, m_tlast are don't-care when m_tvalid = 0.
// TESTING
// - Reset: after areset, m_tvalid=0, s_tready=0, pkt_cnt all 0, first grant goes to src0 when all sources request.
// - N_SRC=4, all four sources continuously send 3-beat packets, m_tready=1 -> packet order 0,1,2,3,0,...
//   - No interleaving; each packet takes 4 cycles (3 beats + 1 IDLE); pkt_cnt[i]=2 after 8 packets.
// - Backpressure: random m_tready at 30% during src2's 5-beat packet -> all 5 beats delivered in order, m_src=2 throughout.
//   - s_tready[0,1,3] stays 0 until src2's tlast is accepted.
// - Sources 1 and 3 request in the same IDLE cycle with ptr=1 -> src3 granted; src1 granted next.
// - Mid-packet stall: src0 drops tvalid for 4 cycles after beat 2 while src1 requests -> grant held on src0, src1 waits.
//   - src1's packet starts only after src0's tlast.
// - Reset on beat 2 of a 4-beat src1 packet -> next cycle m_tvalid=0, pkt_cnt[1]=0, ptr=N_SRC-1.
//   - A subsequent src0/src1 request grants src0.

Source files
------------

// File: rtl/axis_rr_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_rr_pkt_arbiter
// Purpose  : Packet-granular round-robin arbiter that shares one routed
//            AXI4-Stream output (tdata/tkeep/tid/tlast) among N_SRC sources.
//            A granted source owns the output until its tlast beat is
//            accepted, so beats of different packets never interleave.
// Ports    : aclk, areset          - clock, synchronous active-high reset
//            s_tvalid/s_tready     - per-source handshake (N_SRC bits)
//            s_tdata/s_tkeep/s_tid/s_tlast - per-source payload, source i in
//                                    slice i of each flattened vector
//            m_tvalid/m_tready     - output handshake
//            m_tdata/m_tkeep/m_tid/m_tlast - granted source payload
//            m_src                 - granted source index, stable per packet
//            pkt_cnt               - per-source 32-bit accepted-packet count
// Revision : 1.0 - initial release
// ============================================================================
module axis_rr_pkt_arbiter #(
    parameter int N_SRC     = 4,
    parameter int DATA_BITS = 512,
    parameter int ID_BITS   = 6
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [N_SRC-1:0]                 s_tvalid,
    output logic [N_SRC-1:0]                 s_tready,
    input  logic [N_SRC*DATA_BITS-1:0]       s_tdata,
    input  logic [N_SRC*(DATA_BITS/8)-1:0]   s_tkeep,
    input  logic [N_SRC*ID_BITS-1:0]         s_tid,
    input  logic [N_SRC-1:0]                 s_tlast,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic [DATA_BITS-1:0]             m_tdata,
    output logic [DATA_BITS/8-1:0]           m_tkeep,
    output logic [ID_BITS-1:0]               m_tid,
    output logic                             m_tlast,
    output logic [$clog2(N_SRC)-1:0]         m_src,
    output logic [N_SRC*32-1:0]              pkt_cnt
);

    localparam int KEEP_BITS = DATA_BITS / 8;
    localparam int SRC_BITS  = $clog2(N_SRC);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SRC_BITS-1:0]   r_grant;
    logic [SRC_BITS-1:0]   r_ptr;
    logic [SRC_BITS-1:0]   w_pick;
    logic                  w_any_req;
    logic                  w_done;
    logic [31:0]           r_pkt_cnt [N_SRC];

    logic [DATA_BITS-1:0]  w_data [N_SRC];
    logic [KEEP_BITS-1:0]  w_keep [N_SRC];
    logic [ID_BITS-1:0]    w_id   [N_SRC];

    // Unpack the flattened source vectors so the output mux is a plain
    // array index, and flatten the counters back out for status readout.
    generate
        for (genvar i = 0; i < N_SRC; i++) begin : g_src
            assign w_data[i]             = s_tdata[i*DATA_BITS +: DATA_BITS];
            assign w_keep[i]             = s_tkeep[i*KEEP_BITS +: KEEP_BITS];
            assign w_id[i]               = s_tid[i*ID_BITS +: ID_BITS];
            assign pkt_cnt[i*32 +: 32]   = r_pkt_cnt[i];
        end
    endgenerate

    // Round-robin search: first requester starting just after the last
    // granted source, wrapping at N_SRC (which need not be a power of two).
    always_comb begin
        w_pick    = '0;
        w_any_req = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            int                  cand;
            logic [SRC_BITS-1:0] cidx;
            cand = int'(r_ptr) + k;
            if (cand >= N_SRC) begin
                cand = cand - N_SRC;
            end
            cidx = SRC_BITS'(cand);
            if (!w_any_req && s_tvalid[cidx]) begin
                w_any_req = 1'b1;
                w_pick    = cidx;
            end
        end
    end

    // Next state and output path. In BUSY the granted source is routed
    // straight through with no added latency.
    always_comb begin
        w_state_nxt = r_state;
        m_tvalid    = 1'b0;
        m_tdata     = w_data[r_grant];
        m_tkeep     = w_keep[r_grant];
        m_tid       = w_id[r_grant];
        m_tlast     = s_tlast[r_grant];
        s_tready    = '0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                m_tvalid          = s_tvalid[r_grant];
                s_tready[r_grant] = m_tready;
                if (m_tvalid && m_tready && m_tlast) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The pointer starts at the last index so that source 0 wins first.
    // A packet aborted by reset never reaches w_done and is not counted.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_grant <= '0;
            r_ptr   <= SRC_BITS'(N_SRC - 1);
            for (int i = 0; i < N_SRC; i++) begin
                r_pkt_cnt[i] <= '0;
            end
        end else begin
            if (r_state == ST_IDLE && w_any_req) begin
                r_grant <= w_pick;
            end
            if (w_done) begin
                r_ptr              <= r_grant;
                r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + 32'd1;
            end
        end
    end

    assign m_src = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_axis_rr_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_rr_pkt_arbiter
// Purpose  : Self-checking bench for axis_rr_pkt_arbiter. Per-source packet
//            queues drive the inputs; a behavioural arbiter model predicts the
//            outputs each cycle, and directed scenarios pin packet order,
//            counts and timing with hand-computed literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_rr_pkt_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int IW = 6;
    localparam int SB = 2;

    logic              aclk = 1'b0;
    logic              areset;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tready;
    logic [N*DW-1:0]   s_tdata;
    logic [N*KW-1:0]   s_tkeep;
    logic [N*IW-1:0]   s_tid;
    logic [N-1:0]      s_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [IW-1:0]     m_tid;
    logic              m_tlast;
    logic [SB-1:0]     m_src;
    logic [N*32-1:0]   pkt_cnt;

    axis_rr_pkt_arbiter #(
        .N_SRC     (N),
        .DATA_BITS (DW),
        .ID_BITS   (IW)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tid    (s_tid),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tid    (m_tid),
        .m_tlast  (m_tlast),
        .m_src    (m_src),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- source drivers ----------------
    logic [DW-1:0] q_d [N][$];
    bit            q_l [N][$];
    bit [N-1:0]    src_en  = '1;
    bit [N-1:0]    hs_mask = '0;
    int            rdy_pct = 100;

    function automatic logic [DW-1:0] beat_word(input int src, input int pkt, input int beat);
        return {8'(src), 8'(pkt), 8'(beat), 8'hA5};
    endfunction

    task automatic load_pkt(input int src, input int pkt, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            q_d[src].push_back(beat_word(src, pkt, b));
            q_l[src].push_back(b == nbeats - 1);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (q_d[i].size() > 0) begin
                s_tvalid[i]          = src_en[i];
                s_tdata[i*DW +: DW]  = q_d[i][0];
                s_tlast[i]           = q_l[i][0];
                s_tkeep[i*KW +: KW]  = q_l[i][0] ? 4'h7 : 4'hF;
                s_tid[i*IW +: IW]    = 6'(10 + i);
            end else begin
                s_tvalid[i]          = 1'b0;
                s_tdata[i*DW +: DW]  = '0;
                s_tlast[i]           = 1'b0;
                s_tkeep[i*KW +: KW]  = '0;
                s_tid[i*IW +: IW]    = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_mask[i] && q_d[i].size() > 0) begin
                void'(q_d[i].pop_front());
                void'(q_l[i].pop_front());
            end
        end
        m_tready = (int'($urandom_range(0, 99)) < rdy_pct);
        drive();
    endtask

    // ---------------- model + per-cycle compare ----------------
    bit          chk_en  = 1'b0;
    bit          mdl_busy = 1'b0;
    int          mdl_g    = 0;
    int          mdl_ptr  = N - 1;
    int unsigned mdl_cnt [N];
    int          cyc      = 0;

    int            acc_src[$];
    logic [DW-1:0] acc_data[$];
    int            pkt_order[$];
    int            last_cyc[$];

    always @(negedge aclk) begin
        logic [N-1:0] exp_rdy;
        cyc++;
        hs_mask = s_tvalid & s_tready;
        if (chk_en) begin
            exp_rdy = '0;
            if (mdl_busy) exp_rdy[mdl_g] = m_tready;
            check("m_tvalid", m_tvalid, mdl_busy ? s_tvalid[mdl_g] : 1'b0);
            check("s_tready", s_tready, exp_rdy);
            check("m_src", m_src, mdl_g);
            for (int i = 0; i < N; i++)
                check("pkt_cnt", pkt_cnt[i*32 +: 32], mdl_cnt[i]);
            if (mdl_busy && m_tvalid) begin
                check("m_tdata", m_tdata, s_tdata[mdl_g*DW +: DW]);
                check("m_tkeep", m_tkeep, s_tkeep[mdl_g*KW +: KW]);
                check("m_tid",   m_tid,   s_tid[mdl_g*IW +: IW]);
                check("m_tlast", m_tlast, s_tlast[mdl_g]);
            end
            if (!areset && m_tvalid && m_tready) begin
                acc_src.push_back(int'(m_src));
                acc_data.push_back(m_tdata);
                if (m_tlast) begin
                    pkt_order.push_back(int'(m_src));
                    last_cyc.push_back(cyc);
                end
            end
        end
        // Model: who owns the stream, where round-robin resumes, counts.
        if (areset) begin
            mdl_busy = 1'b0;
            mdl_g    = 0;
            mdl_ptr  = N - 1;
            for (int i = 0; i < N; i++) mdl_cnt[i] = 0;
        end else if (!mdl_busy) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (mdl_ptr + k) % N;
                if (s_tvalid[c]) begin
                    mdl_g    = c;
                    mdl_busy = 1'b1;
                    break;
                end
            end
        end else if (s_tvalid[mdl_g] && m_tready && s_tlast[mdl_g]) begin
            mdl_cnt[mdl_g]++;
            mdl_ptr  = mdl_g;
            mdl_busy = 1'b0;
        end
    end

    // ---------------- bounded waits ----------------
    task automatic wait_pkts(input int n, input int budget, input string name);
        int t = 0;
        while (pkt_order.size() < n && t < budget) begin
            tick();
            t++;
        end
        if (pkt_order.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout, got %0d packets, expected %0d", name, pkt_order.size(), n);
        end
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int t = 0;
        while (acc_src.size() < n && t < budget) begin
            tick();
            t++;
        end
        if (acc_src.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout, got %0d beats, expected %0d", name, acc_src.size(), n);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int base_o;
        int base_a;
        int bad;

        areset   = 1'b1;
        m_tready = 1'b1;
        drive();
        tick();
        tick();
        chk_en = 1'b1;
        areset = 1'b0;
        tick();

        // Reset state
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_s_tready", s_tready, 4'h0);
        check("rst_m_src", m_src, 0);
        for (int i = 0; i < N; i++) check("rst_pkt_cnt", pkt_cnt[i*32 +: 32], 0);

        // All sources, two 3-beat packets each, output always ready
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < N; s++) load_pkt(s, p, 3);
        drive();
        wait_pkts(8, 200, "rr_wait");
        for (int k = 0; k < 8; k++) check("rr_order", pkt_order[k], k % 4);
        for (int i = 0; i < N; i++) check("rr_pkt_cnt", pkt_cnt[i*32 +: 32], 2);
        check("rr_span_cycles", last_cyc[7] - last_cyc[0], 28);
        bad = 0;
        for (int b = 0; b < 24; b++) if (acc_src[b] != pkt_order[b / 3]) bad++;
        check("rr_no_interleave", bad, 0);

        // Backpressure on src2's 5-beat packet, others queued behind it
        base_o = pkt_order.size();
        base_a = acc_src.size();
        rdy_pct = 30;
        load_pkt(2, 5, 5);
        drive();
        tick();
        load_pkt(0, 6, 2);
        load_pkt(1, 6, 2);
        load_pkt(3, 6, 2);
        drive();
        wait_pkts(base_o + 1, 400, "bp_wait");
        rdy_pct = 100;
        check("bp_first_pkt", pkt_order[base_o], 2);
        for (int b = 0; b < 5; b++) begin
            check("bp_beat_src", acc_src[base_a + b], 2);
            check("bp_beat_data", acc_data[base_a + b], beat_word(2, 5, b));
        end
        wait_pkts(base_o + 4, 100, "bp_drain");
        check("bp_next3", pkt_order[base_o + 1], 3);
        check("bp_next0", pkt_order[base_o + 2], 0);
        check("bp_next1", pkt_order[base_o + 3], 1);

        // Simultaneous 1 and 3 with pointer at 1
        base_o = pkt_order.size();
        load_pkt(1, 7, 1);
        load_pkt(3, 7, 1);
        drive();
        wait_pkts(base_o + 2, 50, "sim_wait");
        check("sim_first", pkt_order[base_o], 3);
        check("sim_second", pkt_order[base_o + 1], 1);

        // src0 stalls mid-packet while src1 requests
        base_o = pkt_order.size();
        base_a = acc_src.size();
        load_pkt(0, 8, 4);
        drive();
        wait_beats(base_a + 2, 50, "stall_wait");
        src_en[0] = 1'b0;
        load_pkt(1, 8, 2);
        drive();
        for (int c = 0; c < 4; c++) begin
            tick();
            check("stall_m_src", m_src, 0);
            check("stall_m_tvalid", m_tvalid, 1'b0);
            check("stall_s_tready1", s_tready[1], 1'b0);
        end
        src_en[0] = 1'b1;
        drive();
        wait_pkts(base_o + 2, 50, "stall_done");
        check("stall_order0", pkt_order[base_o], 0);
        check("stall_order1", pkt_order[base_o + 1], 1);
        check("stall_last_beat", acc_data[base_a + 3], beat_word(0, 8, 3));
        check("stall_src1_after", acc_src[base_a + 4], 1);
        base_o = pkt_order.size();
        load_pkt(0, 9, 1);
        drive();
        wait_pkts(base_o + 1, 50, "ptr0_wait");
        check("ptr0_pkt", pkt_order[base_o], 0);

        // Reset in the middle of a 4-beat src1 packet
        base_a = acc_src.size();
        load_pkt(1, 10, 4);
        drive();
        wait_beats(base_a + 2, 50, "rstmid_wait");
        areset = 1'b1;
        tick();
        areset = 1'b0;
        for (int i = 0; i < N; i++) begin
            q_d[i].delete();
            q_l[i].delete();
        end
        drive();
        check("rstmid_m_tvalid", m_tvalid, 1'b0);
        check("rstmid_m_src", m_src, 0);
        for (int i = 0; i < N; i++) check("rstmid_pkt_cnt", pkt_cnt[i*32 +: 32], 0);
        base_o = pkt_order.size();
        load_pkt(0, 11, 1);
        load_pkt(1, 11, 1);
        drive();
        wait_pkts(base_o + 2, 50, "rstmid_after");
        check("rstmid_first", pkt_order[base_o], 0);
        check("rstmid_second", pkt_order[base_o + 1], 1);
        tick();
        check("rstmid_cnt0", pkt_cnt[31:0], 1);
        check("rstmid_cnt1", pkt_cnt[63:32], 1);

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
